led_count_allocator: RTL and testbench
======================================

Name: led_count_allocator

Overview:
Upstream stage of the serial LED driver. It converts per-bin note amplitudes into per-bin LED counts that sum exactly to LEDS. Each bin gets floor(amp*LEDS/total) LEDs. The rounding remainder goes to the loudest bin. The count vector feeds the driver's LEDCounts input, and data_v feeds the driver's start.

Parameters:
LEDS, 50, number of LEDs on the strip.
BIN_QTY, 12, number of note bins.
AW, 16, amplitude width (unsigned).
THRESH, 0, amplitude gate level; used only when LED_ALLOC_THRESH_EN is defined.
Derived: CW = $clog2(LEDS+1) is the count width; NW = AW + CW is the dividend width and the number of divide cycles per bin.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
start  in  1  request; sampled only in IDLE.
amplitudes  in  [BIN_QTY-1:0][AW-1:0]  per-bin amplitudes.
LEDCounts  out  [BIN_QTY-1:0][CW-1:0]  per-bin LED counts; sum = LEDS when total != 0.
data_v  out  1  one-cycle pulse: new LEDCounts valid.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; LEDCounts = 0; data_v = 0; busy = 0; all working registers cleared. Reset mid-operation aborts the computation. The next cycle shows IDLE with zeroed outputs.
- States: IDLE, SUM, DIV, FIX, DONE.
- IDLE: on start=1, latch amplitudes into amp_r, clear acc/assigned/maxbin/bin index, go to SUM. start is ignored in every other state (no queuing).
- SUM: runs BIN_QTY cycles, one bin per cycle in index order 0..BIN_QTY-1.
  - acc += amp_r[i]; acc width is AW+$clog2(BIN_QTY), and no overflow is possible.
  - maxbin updates only on strictly greater amplitude, so ties resolve to the lowest index.
  - After bin BIN_QTY-1: if acc == 0, load all working counts = 0 and go to DONE; else go to DIV.
- DIV: per bin, a restoring divide of amp_r[i]*LEDS (NW bits) by acc.
  - One quotient bit per cycle, so NW cycles per bin and BIN_QTY*NW cycles total.
  - Each quotient (<= LEDS, fits CW) goes into work_cnt[i] and is added to assigned.
  - After the last bin, go to FIX.
- FIX: one cycle. work_cnt[maxbin] += LEDS - assigned; the remainder is always 0..BIN_QTY-1. Go to DONE.
- DONE: one cycle. LEDCounts <= work_cnt, data_v = 1. Go to IDLE.
- LEDCounts changes only on the DONE cycle. It is otherwise held stable through the next computation, because the driver may latch it at any time.
- Latency, measured from the clk edge that accepts start to the data_v-high cycle:
  - BIN_QTY + BIN_QTY*NW + 2 cycles for nonzero total.
  - BIN_QTY + 1 cycles for zero total.
- busy = 1 from the cycle after start acceptance through the DONE cycle. The earliest next start acceptance is the cycle after DONE.
- All-zero total: data_v still pulses and all counts are 0.
- Single nonzero bin: that bin gets exactly LEDS.

Optional Feature:
Macro LED_ALLOC_THRESH_EN.
- Defined: at latch, any amplitude < THRESH is stored as 0. Gated bins are excluded from the total and the max search and receive a count of 0.
- Undefined: amplitudes are latched unmodified; THRESH is unused. Timing is identical either way.

Test Plan:
All scenarios use defaults LEDS=50, BIN_QTY=12, AW=16 (NW=22).
1. amp[0]=100, others 0, start pulse -> LEDCounts[0]=50, others 0; data_v one cycle at 278 cycles after acceptance; busy low afterwards.
2. amp[0..2]=10,10,10, others 0 -> floors 16,16,16, remainder 2 to bin0 -> 18,16,16,0...; sum 50.
3. All amplitudes 0 -> all counts 0; data_v at 13 cycles after acceptance.
4. amp[0]=1, amp[1]=3 -> floors 12,37, remainder 1 to bin1 -> 12,38.
5. Start held high during DIV with new amplitudes -> ignored; result matches the first latch. Then a new run with reset asserted mid-DIV -> next cycle busy=0, LEDCounts=0, no data_v.
6. THRESH=5, amp[0]=4, amp[1]=10:
   - With LED_ALLOC_THRESH_EN -> 0,50.
   - Without -> floors 14,35, remainder 1 to bin1 -> 14,36.

Source files
------------

// File: rtl/led_count_allocator_if.sv
// Handshake bundle between the LED count allocator and its neighbours.
// Master drives start/amplitudes; slave returns counts, data_v, busy.
interface led_count_allocator_if #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int AW      = 16
) ();
  localparam int CW = $clog2(LEDS + 1);

  logic                           start;
  logic [BIN_QTY-1:0][AW-1:0]     amplitudes;
  logic [BIN_QTY-1:0][CW-1:0]     LEDCounts;
  logic                           data_v;
  logic                           busy;

  modport master (
    output start, amplitudes,
    input  LEDCounts, data_v, busy
  );

  modport slave (
    input  start, amplitudes,
    output LEDCounts, data_v, busy
  );
endinterface

// File: rtl/led_count_allocator.sv
// Splits LEDS strip LEDs across note bins in proportion to amplitude.
// Optional amplitude gate below THRESH enabled by LED_ALLOC_THRESH_EN.
module led_count_allocator #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int AW      = 16,
  parameter int THRESH  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  led_count_allocator_if.slave bus
);
  localparam int CW = $clog2(LEDS + 1);
  localparam int NW = AW + CW;
  localparam int SW = AW + $clog2(BIN_QTY);
  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam int KW = $clog2(NW);

  typedef enum logic [2:0] {
    IDLE, SUM, DIV, FIX, DONE
  } state_t;

  state_t                      state;
  logic [BIN_QTY-1:0][AW-1:0]  amp_r;
  logic [BIN_QTY-1:0][AW-1:0]  gated;
  logic [SW-1:0]               acc;
  logic [SW-1:0]               rem;
  logic [NW-1:0]               dq;
  logic [KW-1:0]               bit_cnt;
  logic [BW-1:0]               bin;
  logic [BW-1:0]               nbin;
  logic [BW-1:0]               maxbin;
  logic [CW-1:0]               assigned;
  logic [BIN_QTY-1:0][CW-1:0]  work_cnt;
  logic [BIN_QTY-1:0][CW-1:0]  fixed;

  logic [SW-1:0]               acc_nx;
  logic [SW:0]                 rem_sh;
  logic [SW:0]                 rem_df;
  logic                        ge;
  logic [SW-1:0]               rem_nx;
  logic [NW-1:0]               dq_nx;
  logic [NW-1:0]               dvd_first;
  logic [NW-1:0]               dvd_next;
  logic                        last_bin;

  always_comb begin
    gated = bus.amplitudes;
`ifdef LED_ALLOC_THRESH_EN
    for (int i = 0; i < BIN_QTY; i++) begin
      if (int'(bus.amplitudes[i]) < THRESH) gated[i] = '0;
    end
`endif
  end

  // Restoring divide: dq shifts dividend bits out and quotient bits in.
  always_comb begin
    last_bin  = (bin == BW'(BIN_QTY - 1));
    nbin      = last_bin ? '0 : bin + BW'(1);
    acc_nx    = acc + SW'(amp_r[bin]);
    rem_sh    = {rem, dq[NW-1]};
    rem_df    = rem_sh - {1'b0, acc};
    ge        = (rem_sh >= {1'b0, acc});
    rem_nx    = ge ? rem_df[SW-1:0] : rem_sh[SW-1:0];
    dq_nx     = {dq[NW-2:0], ge};
    dvd_first = NW'(amp_r[0]) * NW'(LEDS);
    dvd_next  = NW'(amp_r[nbin]) * NW'(LEDS);
  end

  always_comb begin
    fixed         = work_cnt;
    fixed[maxbin] = work_cnt[maxbin] + (CW'(LEDS) - assigned);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      amp_r         <= '0;
      acc           <= '0;
      rem           <= '0;
      dq            <= '0;
      bit_cnt       <= '0;
      bin           <= '0;
      maxbin        <= '0;
      assigned      <= '0;
      work_cnt      <= '0;
      bus.LEDCounts <= '0;
      bus.data_v    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.data_v <= 1'b0;
          if (bus.start) begin
            amp_r    <= gated;
            acc      <= '0;
            assigned <= '0;
            maxbin   <= '0;
            bin      <= '0;
            bus.busy <= 1'b1;
            state    <= SUM;
          end
        end
        SUM: begin
          acc <= acc_nx;
          if (amp_r[bin] > amp_r[maxbin]) maxbin <= bin;
          if (last_bin) begin
            bin <= '0;
            if (acc_nx == '0) begin
              work_cnt      <= '0;
              bus.LEDCounts <= '0;
              bus.data_v    <= 1'b1;
              state         <= DONE;
            end else begin
              dq      <= dvd_first;
              rem     <= '0;
              bit_cnt <= '0;
              state   <= DIV;
            end
          end else begin
            bin <= nbin;
          end
        end
        DIV: begin
          rem     <= rem_nx;
          dq      <= dq_nx;
          bit_cnt <= bit_cnt + KW'(1);
          if (bit_cnt == KW'(NW - 1)) begin
            bit_cnt       <= '0;
            work_cnt[bin] <= dq_nx[CW-1:0];
            assigned      <= assigned + dq_nx[CW-1:0];
            rem           <= '0;
            if (last_bin) begin
              state <= FIX;
            end else begin
              bin <= nbin;
              dq  <= dvd_next;
            end
          end
        end
        FIX: begin
          work_cnt      <= fixed;
          bus.LEDCounts <= fixed;
          bus.data_v    <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.data_v <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_count_allocator.sv
// Randomized and directed checks of led_count_allocator against a
// proportional-share reference model.
module tb_led_count_allocator;
  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int AW      = 16;
  localparam int THRESH  = 5;
  localparam int CW      = $clog2(LEDS + 1);
  localparam int NW      = AW + CW;
  localparam int LAT_NZ  = BIN_QTY + BIN_QTY * NW + 2;
  localparam int LAT_Z   = BIN_QTY + 1;

  typedef int arr_t [BIN_QTY];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_count_allocator_if #(
    .LEDS(LEDS), .BIN_QTY(BIN_QTY), .AW(AW)
  ) bus ();

  led_count_allocator #(
    .LEDS(LEDS), .BIN_QTY(BIN_QTY),
    .AW(AW), .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input arr_t a, output arr_t c,
                                output longint tot);
    arr_t   g;
    int     mx;
    int     sum;
    tot = 0;
    mx  = 0;
    sum = 0;
    for (int i = 0; i < BIN_QTY; i++) begin
      g[i] = a[i];
`ifdef LED_ALLOC_THRESH_EN
      if (g[i] < THRESH) g[i] = 0;
`endif
      tot += g[i];
      c[i] = 0;
    end
    if (tot == 0) return;
    for (int i = 0; i < BIN_QTY; i++) begin
      if (g[i] > g[mx]) mx = i;
      c[i] = int'((longint'(g[i]) * LEDS) / tot);
      sum += c[i];
    end
    c[mx] += LEDS - sum;
  endfunction

  task automatic run(input arr_t a, input bit hold_start);
    arr_t   exp_c;
    longint tot;
    logic [BIN_QTY-1:0][CW-1:0] prev;
    int     cyc;
    int     dsum;
    bit     changed;
    model(a, exp_c, tot);
    @(negedge clk);
    for (int i = 0; i < BIN_QTY; i++) bus.amplitudes[i] = AW'(a[i]);
    bus.start = 1'b1;
    prev = bus.LEDCounts;
    @(posedge clk);
    #1;
    if (!hold_start) bus.start = 1'b0;
    cyc = 1;
    changed = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    while (!bus.data_v && cyc < 1000) begin
      if (bus.LEDCounts !== prev) changed = 1'b1;
      if (hold_start) begin
        if (cyc >= 40) bus.start = 1'b0;
        else
          for (int i = 0; i < BIN_QTY; i++)
            bus.amplitudes[i] = AW'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("data_v_seen", bus.data_v, 1);
    chk("latency", cyc, (tot == 0) ? LAT_Z : LAT_NZ);
    chk("counts_held", changed, 0);
    dsum = 0;
    for (int i = 0; i < BIN_QTY; i++) begin
      chk($sformatf("cnt[%0d]", i), bus.LEDCounts[i], exp_c[i]);
      dsum += int'(bus.LEDCounts[i]);
    end
    chk("sum", dsum, (tot == 0) ? 0 : LEDS);
    @(posedge clk);
    #1;
    chk("data_v_pulse", bus.data_v, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  arr_t a;
  int   dv_cnt;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.amplitudes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_data_v", bus.data_v, 0);
    chk("rst_counts", bus.LEDCounts == '0, 1);
    @(negedge clk);
    rst = 1'b0;

    foreach (a[i]) a[i] = 0;
    a[0] = 100;
    run(a, 0);

    foreach (a[i]) a[i] = 0;
    a[0] = 10; a[1] = 10; a[2] = 10;
    run(a, 0);

    foreach (a[i]) a[i] = 0;
    run(a, 0);

    foreach (a[i]) a[i] = 0;
    a[0] = 1; a[1] = 3;
    run(a, 0);

    foreach (a[i]) a[i] = 0;
    a[3] = 700; a[7] = 2100; a[9] = 2100;
    run(a, 1);

    foreach (a[i]) a[i] = 0;
    a[0] = 4; a[1] = 10;
    run(a, 0);

    foreach (a[i]) a[i] = 65535;
    run(a, 0);

    for (int r = 0; r < 15; r++) begin
      foreach (a[i]) begin
        if ($urandom_range(0, 2) == 0) a[i] = 0;
        else a[i] = int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      end
      run(a, 0);
    end

    foreach (a[i]) a[i] = i + 1;
    @(negedge clk);
    for (int i = 0; i < BIN_QTY; i++) bus.amplitudes[i] = AW'(a[i]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_data_v", bus.data_v, 0);
    chk("midrst_counts", bus.LEDCounts == '0, 1);
    @(negedge clk);
    rst = 1'b0;
    dv_cnt = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (bus.data_v) dv_cnt++;
    end
    chk("midrst_no_data_v", dv_cnt, 0);
    chk("midrst_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
